// File: rtl/watch_edit_sequencer.sv
// Display-mode owner and set-value edit session controller for the watch datapath.
// Preloads time/alarm/day into an edit buffer, applies BCD limits, issues commit strobes.
module watch_edit_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned BLINK_DIV   = 50
) (
  input  logic       clk,
  input  logic       resetTime,
  input  logic       modeBtn,
  input  logic       setBtn,
  input  logic       nextBtn,
  input  logic       upBtn,
  input  logic [3:0] curHour1,
  input  logic [3:0] curHour0,
  input  logic [3:0] curMin1,
  input  logic [3:0] curMin0,
  input  logic [3:0] almHour1,
  input  logic [3:0] almHour0,
  input  logic [3:0] almMin1,
  input  logic [3:0] almMin0,
  input  logic [2:0] curDay,
  output logic [2:0] mode,
  output logic       setValue,
  output logic [1:0] editField,
  output logic [3:0] edHour1,
  output logic [3:0] edHour0,
  output logic [3:0] edMin1,
  output logic [3:0] edMin0,
  output logic [2:0] edDay,
  output logic       blink,
  output logic       commitWatch,
  output logic       commitAlarm,
  output logic       commitDay
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BlkMax = BW'(BLINK_DIV - 1);

  localparam logic [2:0] ModeWatch = 3'd0;
  localparam logic [2:0] ModeStop  = 3'd1;
  localparam logic [2:0] ModeAlarm = 3'd2;
  localparam logic [2:0] ModeDay   = 3'd3;

  typedef enum logic [2:0] {StIdle, StEH1, StEH0, StEM1, StEM0, StEDay} state_e;

  state_e        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic [3:0]    h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic [2:0]    day_q, day_d;
  logic          blink_q, blink_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cw_q, cw_d, ca_q, ca_d, cd_q, cd_d;
  logic          any_btn;

  assign any_btn = modeBtn | setBtn | nextBtn | upBtn;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    h1_d      = h1_q;
    h0_d      = h0_q;
    m1_d      = m1_q;
    m0_d      = m0_q;
    day_d     = day_q;
    blink_d   = blink_q;
    blk_cnt_d = blk_cnt_q;
    tmo_d     = tmo_q;
    cw_d      = 1'b0;
    ca_d      = 1'b0;
    cd_d      = 1'b0;

    case (state_q)
      StIdle: begin
        blink_d   = 1'b0;
        blk_cnt_d = '0;
        tmo_d     = '0;
        if (setBtn) begin
          unique case (mode_q)
            ModeWatch: begin
              {h1_d, h0_d, m1_d, m0_d} = {curHour1, curHour0, curMin1, curMin0};
              state_d = StEH1;
            end
            ModeAlarm: begin
              {h1_d, h0_d, m1_d, m0_d} = {almHour1, almHour0, almMin1, almMin0};
              state_d = StEH1;
            end
            ModeDay: begin
              day_d   = curDay;
              state_d = StEDay;
            end
            default: ;
          endcase
          if (mode_q != ModeStop) blink_d = 1'b1;
        end else if (!(nextBtn || upBtn) && modeBtn) begin
          mode_d = (mode_q == ModeDay) ? ModeWatch : mode_q + 3'd1;
        end
      end
      default: begin
        if (setBtn) begin
          state_d = StIdle;
          blink_d = 1'b0;
          cw_d    = (mode_q == ModeWatch);
          ca_d    = (mode_q == ModeAlarm);
          cd_d    = (mode_q == ModeDay);
        end else if (any_btn) begin
          // Any pulse, even an ignored one, restarts the blink phase and the timeout.
          tmo_d     = '0;
          blink_d   = 1'b1;
          blk_cnt_d = '0;
          if (nextBtn) begin
            case (state_q)
              StEH1:   state_d = StEH0;
              StEH0:   state_d = StEM1;
              StEM1:   state_d = StEM0;
              StEM0:   state_d = StEH1;
              default: ;
            endcase
          end else if (upBtn) begin
            case (state_q)
              StEH1: begin
                if (h1_q >= 4'd2) begin
                  h1_d = 4'd0;
                end else begin
                  h1_d = h1_q + 4'd1;
                  if (h1_q == 4'd1 && h0_q > 4'd3) h0_d = 4'd3;
                end
              end
              StEH0:   h0_d  = (h0_q >= ((h1_q == 4'd2) ? 4'd3 : 4'd9)) ? 4'd0 : h0_q + 4'd1;
              StEM1:   m1_d  = (m1_q >= 4'd5) ? 4'd0 : m1_q + 4'd1;
              StEM0:   m0_d  = (m0_q >= 4'd9) ? 4'd0 : m0_q + 4'd1;
              StEDay:  day_d = (day_q >= 3'd6) ? 3'd0 : day_q + 3'd1;
              default: ;
            endcase
          end
        end else if (tmo_q == TmoMax) begin
          state_d = StIdle;
          blink_d = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (blk_cnt_q == BlkMax) begin
            blink_d   = ~blink_q;
            blk_cnt_d = '0;
          end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetTime) begin
      state_q   <= StIdle;
      mode_q    <= ModeWatch;
      h1_q      <= '0;
      h0_q      <= '0;
      m1_q      <= '0;
      m0_q      <= '0;
      day_q     <= '0;
      blink_q   <= 1'b0;
      blk_cnt_q <= '0;
      tmo_q     <= '0;
      cw_q      <= 1'b0;
      ca_q      <= 1'b0;
      cd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      h1_q      <= h1_d;
      h0_q      <= h0_d;
      m1_q      <= m1_d;
      m0_q      <= m0_d;
      day_q     <= day_d;
      blink_q   <= blink_d;
      blk_cnt_q <= blk_cnt_d;
      tmo_q     <= tmo_d;
      cw_q      <= cw_d;
      ca_q      <= ca_d;
      cd_q      <= cd_d;
    end
  end

  always_comb begin
    editField = 2'd0;
    case (state_q)
      StEH0:   editField = 2'd1;
      StEM1:   editField = 2'd2;
      StEM0:   editField = 2'd3;
      default: editField = 2'd0;
    endcase
  end

  assign setValue    = (state_q != StIdle);
  assign mode        = mode_q;
  assign edHour1     = h1_q;
  assign edHour0     = h0_q;
  assign edMin1      = m1_q;
  assign edMin0      = m0_q;
  assign edDay       = day_q;
  assign blink       = blink_q;
  assign commitWatch = cw_q;
  assign commitAlarm = ca_q;
  assign commitDay   = cd_q;

endmodule

// File: doc/watch_edit_sequencer.md
# watch_edit_sequencer

Mode and edit-session controller for the watch datapath. It owns the display mode (WATCH / STOPWATCH / ALARM / DAY) and runs the set-value edit session: it preloads the current time, alarm or day, steps through digits, and applies BCD range limits. It then issues one-cycle commit strobes that load the edited value into the watch counter, the alarm register or the day register. It sits between the button synchronizers and the watch/alarm/day datapath, and replaces ad-hoc setValue gating in the display controller.

## Interface
- TIMEOUT_CYC, 1000: idle cycles with no button pulse before an edit aborts (≥2).
- BLINK_DIV, 50: cycles per half-period of the edit-digit blink (≥1).

- clk  in  1  system clock; all logic on posedge.
- resetTime  in  1  synchronous, active-low reset.
- modeBtn, setBtn, nextBtn, upBtn  in  1 each  single-cycle pulses, already debounced and synchronized upstream.
- curHour1, curHour0, curMin1, curMin0  in  4 each  live watch time (BCD), preload for a WATCH edit.
- almHour1, almHour0, almMin1, almMin0  in  4 each  stored alarm (BCD), preload for an ALARM edit.
- curDay  in  3  live day of week (0–6), preload for a DAY edit.
- mode  out  3  000 WATCH, 001 STOPWATCH, 010 ALARM, 011 DAY; 1xx is never driven.
- setValue  out  1  high for the whole edit session.
- editField  out  2  digit under edit: 0 H1, 1 H0, 2 M1, 3 M0; 0 in DAY edit.
- edHour1, edHour0, edMin1, edMin0  out  4 each  edit-buffer BCD digits.
- edDay  out  3  edit-buffer day.
- blink  out  1  blank strobe for the digit under edit.
- commitWatch, commitAlarm, commitDay  out  1 each  one-cycle load strobes.

## Operation
- States: IDLE, E_H1, E_H0, E_M1, E_M0, E_DAY.
- Button priority when several pulses arrive in one cycle: set > next > up > mode. Lower-priority pulses in that cycle are dropped.
- In IDLE:
  - modeBtn steps the mode: WATCH→STOPWATCH→ALARM→DAY→WATCH.
  - setBtn in WATCH loads ed* from cur*, enters E_H1 and asserts setValue.
  - setBtn in ALARM does the same but loads ed* from alm*.
  - setBtn in DAY loads edDay from curDay and enters E_DAY.
  - setBtn in STOPWATCH is ignored.
  - nextBtn and upBtn are ignored in IDLE.
- In any edit state, modeBtn is ignored; mode is frozen.
- nextBtn cycles E_H1→E_H0→E_M1→E_M0→E_H1. It is ignored in E_DAY.
- upBtn increments the field under edit, with wrap:
  - H1: 0→1→2→0. If H1 becomes 2 and H0>3, H0 is clamped to 3 in the same cycle.
  - H0: 0–9 when H1<2; 0–3 when H1=2; wraps to 0.
  - M1: 0–5. M0: 0–9.
  - edDay: 0–6, wraps to 0.
- setBtn in any edit state commits:
  - Return to IDLE and deassert setValue.
  - Pulse commitWatch (mode WATCH), commitAlarm (ALARM) or commitDay (DAY) for exactly one cycle.
  - ed* hold the committed value until the next preload.
- Timeout: an inactivity counter clears on entry to an edit state and on every button pulse. When it reaches TIMEOUT_CYC−1, the session aborts to IDLE with no commit strobe. ed* keep their last values.
- Blink: 0 in IDLE. On edit entry and on every button pulse during an edit, blink goes to 1 and the blink counter clears. Thereafter blink toggles every BLINK_DIV cycles.
- Downstream must treat ed* as valid for loading only when a commit* strobe is high.

## Timing
- All outputs are registered. A pulse in cycle N is reflected in state, outputs and strobes in cycle N+1.
- A commit strobe is high in cycle N+1 after the setBtn in cycle N. In that same cycle setValue is 0 and ed* hold the final values.
- Preload samples cur*/alm*/curDay in the cycle of the setBtn pulse.
- Timeout abort is visible at the cycle after the counter reaches TIMEOUT_CYC−1. A button pulse arriving in that same cycle wins: it is processed and the counter clears.
- Reset (resetTime=0 at a clock edge) applies regardless of state, including mid-edit, and no strobe is issued. Values after reset:
  - state IDLE, mode 000, setValue 0, editField 0
  - ed* 0, edDay 0, blink 0, all commit* 0, counters 0
- The three commit strobes are mutually exclusive and never high for two consecutive cycles.

## Test plan
- Mode cycling: reset, then 4 modeBtn pulses → mode 001, 010, 011, 000. A setBtn in STOPWATCH leaves setValue=0.
- Watch edit:
  - Preload cur=23:59.
  - setBtn, upBtn ×2 → H1 2→0→1.
  - nextBtn, upBtn → H0 3→4.
  - setBtn → commitWatch=1 for one cycle with ed=14:59; setValue=0 in that same cycle.
- Clamp: preload 19:00, upBtn on H1 → ed=23:00.
- Alarm edit with simultaneous buttons:
  - mode ALARM, alm=07:30.
  - setBtn → ed=07:30.
  - setBtn+upBtn in the same cycle → commit only (commitAlarm=1, ed=07:30, no increment).
- Timeout: with TIMEOUT_CYC=8, enter a WATCH edit and apply no buttons → IDLE after 8 cycles, no strobe.
  - Repeat with an upBtn on cycle 5 → the session persists to cycle 13.
- DAY edit and reset:
  - curDay=6, setBtn, upBtn → edDay=0.
  - Assert resetTime mid-edit → all outputs at reset values, no commitDay.
